// File: rtl/uart_arbiter.sv
// rtl/uart_arbiter.sv - round-robin owner arbiter sharing one UART register port between cores
module uart_arbiter #(
  parameter int NUM_CPU  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CPU-1:0]        i_req,
  input  logic [NUM_CPU-1:0]        i_cpu_wr,
  input  logic [NUM_CPU-1:0]        i_cpu_rd,
  input  logic [2*NUM_CPU-1:0]      i_cpu_addr,
  input  logic [DATA_W*NUM_CPU-1:0] i_cpu_din,
  output logic [NUM_CPU-1:0]        o_gnt,
  output logic [DATA_W-1:0]         o_cpu_rdata,
  output logic [DATA_W-1:0]         o_cpu_rdata1,
  output logic [NUM_CPU-1:0]        o_cpu_rvalid,
  output logic                      o_uart_wr,
  output logic                      o_uart_rd,
  output logic [1:0]                o_uart_addr,
  output logic [DATA_W-1:0]         o_uart_din,
  input  logic [DATA_W-1:0]         i_uart_dout,
  input  logic [DATA_W-1:0]         i_uart_dout1
);

  localparam int          PTR_W     = $clog2(NUM_CPU);
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(MAX_HOLD);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                w_release;

  // r_ptr is the current owner while in S_OWN and the last-served core while idle
  logic [PTR_W-1:0]    r_ptr;
  logic [15:0]         r_hold;
  logic [NUM_CPU-1:0]  r_gnt;
  logic [NUM_CPU-1:0]  r_rd_oh;
  logic [NUM_CPU-1:0]  r_rvalid;
  logic                r_uart_wr;
  logic                r_uart_rd;
  logic [1:0]          r_uart_addr;
  logic [DATA_W-1:0]   r_uart_din;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_own_req;
  logic                w_own_wr;
  logic                w_own_rd;
  logic [1:0]          w_own_addr;
  logic [DATA_W-1:0]   w_own_din;

  logic                w_found_hi;
  logic [PTR_W-1:0]    w_sel_hi;
  logic [PTR_W-1:0]    w_sel_lo;
  logic [PTR_W-1:0]    w_sel;
  logic [NUM_CPU-1:0]  w_sel_oh;

  // Pick out the owner's request, strobes, address and data slice
  always_comb begin
    w_own_req  = 1'b0;
    w_own_wr   = 1'b0;
    w_own_rd   = 1'b0;
    w_own_addr = '0;
    w_own_din  = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      if (r_ptr == PTR_W'(i)) begin
        w_own_req  = i_req[i];
        w_own_wr   = i_cpu_wr[i];
        w_own_rd   = i_cpu_rd[i];
        w_own_addr = i_cpu_addr[2*i +: 2];
        w_own_din  = i_cpu_din[DATA_W*i +: DATA_W];
      end
    end
  end

  // Round-robin pick: lowest requester above the pointer, else lowest at or below it
  always_comb begin
    w_found_hi = 1'b0;
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (PTR_W'(i) > r_ptr) begin
          w_found_hi = 1'b1;
          w_sel_hi   = PTR_W'(i);
        end else begin
          w_sel_lo   = PTR_W'(i);
        end
      end
    end
    w_sel = w_found_hi ? w_sel_hi : w_sel_lo;
    for (int i = 0; i < NUM_CPU; i++) begin
      w_sel_oh[i] = (w_sel == PTR_W'(i));
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: grant on any request, release on dropped request or hold limit
  always_comb begin
    w_next_state = r_state;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) w_next_state = S_IDLE == S_IDLE ? S_OWN : S_IDLE;
      end
      S_OWN: begin
        w_release = !w_own_req || (r_hold == HOLD_LAST);
        if (w_release) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Grant, hold counter, registered forwarding to the UART and read capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr       <= PTR_W'(NUM_CPU - 1);
      r_hold      <= '0;
      r_gnt       <= '0;
      r_rd_oh     <= '0;
      r_rvalid    <= '0;
      r_uart_wr   <= 1'b0;
      r_uart_rd   <= 1'b0;
      r_uart_addr <= '0;
      r_uart_din  <= '0;
      r_rdata     <= '0;
      r_rdata1    <= '0;
    end else begin
      r_uart_wr <= 1'b0;
      r_uart_rd <= 1'b0;
      r_rvalid  <= '0;
      // r_rd_oh remembers who issued the read, so a release before capture is harmless
      if (r_uart_rd) begin
        r_rdata  <= i_uart_dout;
        r_rdata1 <= i_uart_dout1;
        r_rvalid <= r_rd_oh;
      end
      case (r_state)
        S_IDLE: begin
          if (|i_req) begin
            r_gnt  <= w_sel_oh;
            r_ptr  <= w_sel;
            r_hold <= '0;
          end
        end
        S_OWN: begin
          r_uart_wr   <= w_own_wr;
          r_uart_rd   <= w_own_rd;
          r_uart_addr <= w_own_addr;
          r_uart_din  <= w_own_din;
          r_rd_oh     <= r_gnt;
          if (w_release) r_gnt <= '0;
          if (r_hold != HOLD_MAX) r_hold <= r_hold + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_gnt        = r_gnt;
  assign o_cpu_rdata  = r_rdata;
  assign o_cpu_rdata1 = r_rdata1;
  assign o_cpu_rvalid = r_rvalid;
  assign o_uart_wr    = r_uart_wr;
  assign o_uart_rd    = r_uart_rd;
  assign o_uart_addr  = r_uart_addr;
  assign o_uart_din   = r_uart_din;

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
- Shares the single UART register interface (wr/rd/adr/din/dout/dout1) between NUM_CPU J1 cores in the multi-core build.
- Each core raises a request and holds it for the length of its UART transaction, for example a status poll followed by a data write.
- The block grants one core at a time, round-robin, and forwards only the owner's strobes to the UART. It returns read data to the owner and enforces a hold timeout so one core cannot starve the others.

Parameters:
- NUM_CPU, 4, number of requesting cores (2..8).
- DATA_W, 8, UART data width.
- MAX_HOLD, 255, maximum consecutive granted cycles before a forced release (1..65535).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CPU  per-core request; hold high for the whole transaction.
- cpu_wr  in  NUM_CPU  per-core UART write strobe.
- cpu_rd  in  NUM_CPU  per-core UART read strobe.
- cpu_addr  in  2*NUM_CPU  per-core UART register address; core i uses bits [2i+1:2i].
- cpu_din  in  DATA_W*NUM_CPU  per-core write data; core i uses slice i.
- gnt  out  NUM_CPU  one-hot grant, registered.
- cpu_rdata  out  DATA_W  captured read data, shared by all cores.
- cpu_rdata1  out  DATA_W  captured secondary read data (from uart_dout1), shared by all cores.
- cpu_rvalid  out  NUM_CPU  one-cycle pulse to the owner when cpu_rdata/cpu_rdata1 are valid.
- uart_wr  out  1  to UART wr.
- uart_rd  out  1  to UART rd.
- uart_addr  out  2  to UART adr.
- uart_din  out  DATA_W  to UART din.
- uart_dout  in  DATA_W  from UART dout; combinational in adr.
- uart_dout1  in  DATA_W  from UART dout1.

Behaviour:
- Reset (rst=1 at a clock edge): all outputs 0; state=IDLE; last-grant pointer=NUM_CPU-1, so core 0 has first priority; hold counter=0.
- Reset mid-transaction aborts the grant immediately. No strobe is issued in the cycle after reset.
- States: IDLE, OWN.
- IDLE:
  - If req is nonzero, select the first set bit searching upward from pointer+1, wrapping modulo NUM_CPU.
  - Next cycle: gnt is one-hot for the selected core, pointer=owner, state=OWN, hold counter=0.
  - If req=0, stay in IDLE with gnt=0.
- OWN, forwarding:
  - Signals are registered with 1-cycle latency: uart_wr<=cpu_wr[owner], uart_rd<=cpu_rd[owner], uart_addr<=cpu_addr[owner], uart_din<=cpu_din[owner].
  - uart_wr and uart_rd are pulses of the same length as the owner's strobes.
  - Strobes from non-owners are ignored and dropped, never queued.
  - uart_addr/uart_din hold their last value while idle.
- OWN, read return:
  - In the cycle where uart_rd=1, capture cpu_rdata<=uart_dout and cpu_rdata1<=uart_dout1.
  - cpu_rvalid[owner] pulses in the same cycle as that capture, i.e. 2 cycles after cpu_rd[owner].
  - If a release happens between strobe and capture, the read is still delivered to the core that issued it.
- OWN, hold counter:
  - Increments each cycle, saturating at MAX_HOLD.
- Release: leave OWN when req[owner]=0 or the hold counter reaches MAX_HOLD-1.
  - On release, the next cycle has gnt=0 and state=IDLE. A new owner is granted one cycle later, so there is a 1-cycle dead gap between owners.
  - The pointer advances past the released owner, so a forced-release core is served last among current requesters.
- Simultaneous release and strobe: a strobe present in the last OWN cycle is still forwarded. Strobes during the dead cycle are dropped.
- Owner asserting wr and rd in the same cycle: both are forwarded, since the UART defines their combined effect.
- A core that still holds req high after a forced release is re-granted only after all other requesting cores have been served once.

Test Plan:
- Single owner: req=0001, one wr to addr 2 with din 0x41 in cycle 3 after gnt -> gnt=0001 one cycle after req; uart_wr=1, uart_addr=2, uart_din=0x41 exactly one cycle after cpu_wr.
- Read path: owner core 2 does cpu_rd addr 1 with uart_dout=0x5A, uart_dout1=0x07 -> cpu_rvalid=0100 two cycles after cpu_rd; cpu_rdata=0x5A; cpu_rdata1=0x07.
- Round-robin: req=1111 held, each core drops req after 4 cycles and re-raises it -> grant order 0,1,2,3,0 with exactly one gnt=0 cycle between owners.
- Non-owner isolation: core 0 owns; core 3 pulses cpu_wr with din 0xFF -> uart_wr stays 0 for that strobe; uart_din does not change to 0xFF.
- Timeout: MAX_HOLD=8, core 1 holds req forever, core 2 requests -> gnt[1] drops after 8 cycles; gnt=0100 two cycles later; core 1 re-granted after core 2 releases.
- Reset mid-op: assert rst while core 0 owns and a wr is in flight -> next cycle gnt=0, uart_wr=0, cpu_rvalid=0; after rst drops with req=1000, core 3 is granted one cycle later.
